// File: rtl/datapath_seq_if.sv
// Command handshake and datapath control bundle between a requester and the
// datapath_seq sequencer.
interface datapath_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [4:0] cmd_aluc;
  logic [4:0] cmd_rs;
  logic [4:0] cmd_rt;
  logic [4:0] cmd_rd;

  logic [4:0] r1;
  logic [4:0] r2;
  logic [4:0] wr_addr;
  logic [4:0] ALUc;
  logic       regw;
  logic       memw;
  logic       memr;
  logic       busy;
  logic       done;
  logic       err;

  // Requester side: issues commands, observes datapath control.
  modport master (
    output cmd_valid, cmd_op, cmd_aluc, cmd_rs, cmd_rt, cmd_rd,
    input  cmd_ready, r1, r2, wr_addr, ALUc, regw, memw, memr, busy, done, err
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_aluc, cmd_rs, cmd_rt, cmd_rd,
    output cmd_ready, r1, r2, wr_addr, ALUc, regw, memw, memr, busy, done, err
  );
endinterface

// File: rtl/datapath_seq.sv
// Multi-cycle command sequencer: accepts ALU/LOAD/STORE/NOP commands and steps
// the datapath through DECODE/EXEC/MEM/WB with fully registered control outputs.
module datapath_seq (
  input  logic          clk,
  input  logic          reset,
  datapath_seq_if.slave bus
);

  localparam logic [2:0] OpAlu   = 3'd0;
  localparam logic [2:0] OpLoad  = 3'd1;
  localparam logic [2:0] OpStore = 3'd2;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [4:0] rs_q, rs_d;
  logic [4:0] rt_q, rt_d;
  logic [4:0] rd_q, rd_d;
  logic [4:0] aluc_q, aluc_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       regw_q, regw_d;
  logic       memw_q, memw_d;
  logic       memr_q, memr_d;

  logic hs;
  logic multi_cycle;

  // Handshake is only possible in IDLE, so cmd_* are ignored while busy.
  assign hs          = bus.cmd_valid && (state_q == StIdle);
  assign multi_cycle = (bus.cmd_op == OpAlu) || (bus.cmd_op == OpLoad) ||
                       (bus.cmd_op == OpStore);

  always_comb begin
    op_d   = op_q;
    rs_d   = rs_q;
    rt_d   = rt_q;
    rd_d   = rd_q;
    aluc_d = aluc_q;
    if (hs) begin
      op_d   = bus.cmd_op;
      rs_d   = bus.cmd_rs;
      rt_d   = bus.cmd_rt;
      rd_d   = bus.cmd_rd;
      aluc_d = bus.cmd_aluc;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (hs && multi_cycle) begin
          state_d = StDecode;
        end
      end
      StDecode: state_d = StExec;
      StExec:   state_d = (op_q == OpAlu) ? StWb : StMem;
      StMem:    state_d = (op_q == OpLoad) ? StWb : StIdle;
      StWb:     state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so the registered copies line up
  // with the state they describe.
  always_comb begin
    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);
    regw_d  = (state_d == StWb);
    memw_d  = (state_d == StMem) && (op_d == OpStore);
    memr_d  = ((state_d == StMem) || (state_d == StWb)) && (op_d == OpLoad);
    done_d  = (state_q == StWb) ||
              ((state_q == StMem) && (op_q == OpStore)) ||
              (hs && !multi_cycle);
    err_d   = hs && bus.cmd_op[2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= 3'd0;
      rs_q    <= 5'd0;
      rt_q    <= 5'd0;
      rd_q    <= 5'd0;
      aluc_q  <= 5'd0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      regw_q  <= 1'b0;
      memw_q  <= 1'b0;
      memr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      aluc_q  <= aluc_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      regw_q  <= regw_d;
      memw_q  <= memw_d;
      memr_q  <= memr_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.regw      = regw_q;
  assign bus.memw      = memw_q;
  assign bus.memr      = memr_q;
  assign bus.r1        = rs_q;
  assign bus.r2        = rt_q;
  assign bus.wr_addr   = rd_q;
  assign bus.ALUc      = aluc_q;

endmodule

// File: tb/tb_datapath_seq.sv
// Self-checking bench for datapath_seq: directed table, reset corner cases and
// randomized commands against a per-cycle behavioural model.
module tb_datapath_seq;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  datapath_seq_if bus ();

  datapath_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [4:0] aluc;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    int         lat;
    int         err;
    int         nregw;
    int         nmemw;
    int         nmemr;
  } vec_t;

  logic [4:0] last_rs, last_rt, last_rd, last_aluc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] ctl_now();
    return {bus.cmd_ready, bus.busy, bus.done, bus.err, bus.regw, bus.memw, bus.memr};
  endfunction

  function automatic logic [19:0] addr_now();
    return {bus.r1, bus.r2, bus.wr_addr, bus.ALUc};
  endfunction

  function automatic int latency_of(input logic [2:0] op);
    case (op)
      3'd0:    return 4;
      3'd1:    return 5;
      3'd2:    return 4;
      default: return 1;
    endcase
  endfunction

  // Called at a negedge with the sequencer expected idle; returns at the negedge
  // of the done cycle with cmd_valid low, so the caller may issue back-to-back.
  task automatic run_cmd(input logic [2:0] op, input logic [4:0] aluc, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, output int o_lat,
                         output int o_err, output int o_regw, output int o_memw,
                         output int o_memr);
    int         lat;
    logic       e_regw, e_memw, e_memr, fin;
    logic [6:0] exp_ctl;
    lat = latency_of(op);
    check("ready_at_present", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_aluc  = aluc;
    bus.cmd_rs    = rs;
    bus.cmd_rt    = rt;
    bus.cmd_rd    = rd;
    last_rs = rs; last_rt = rt; last_rd = rd; last_aluc = aluc;
    o_lat = 0; o_err = 0; o_regw = 0; o_memw = 0; o_memr = 0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      fin    = (k == lat);
      e_regw = !fin && (((op == 3'd0) && (k == 3)) || ((op == 3'd1) && (k == 4)));
      e_memw = !fin && (op == 3'd2) && (k == 3);
      e_memr = !fin && (op == 3'd1) && ((k == 3) || (k == 4));
      exp_ctl = {fin, !fin, fin, fin && op[2], e_regw, e_memw, e_memr};
      check("ctl", 32'(ctl_now()), 32'(exp_ctl));
      check("addr", 32'(addr_now()), 32'({rs, rt, rd, aluc}));
      if (bus.done && (o_lat == 0)) o_lat = k;
      o_err  += int'(bus.err);
      o_regw += int'(bus.regw);
      o_memw += int'(bus.memw);
      o_memr += int'(bus.memr);
      if (!fin) begin
        // Garbage on the command inputs must be ignored while busy.
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_op    = 3'($urandom);
        bus.cmd_aluc  = 5'($urandom);
        bus.cmd_rs    = 5'($urandom);
        bus.cmd_rt    = 5'($urandom);
        bus.cmd_rd    = 5'($urandom);
      end else begin
        bus.cmd_valid = 1'b0;
      end
    end
  endtask

  vec_t tbl[8];
  int   o_lat, o_err, o_regw, o_memw, o_memr;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_aluc  = 5'd0;
    bus.cmd_rs    = 5'd0;
    bus.cmd_rt    = 5'd0;
    bus.cmd_rd    = 5'd0;

    tbl[0] = '{3'd0, 5'b00010, 5'd0, 5'd1, 5'd2, 4, 0, 1, 0, 0};
    tbl[1] = '{3'd1, 5'd0,     5'd3, 5'd4, 5'd7, 5, 0, 1, 0, 2};
    tbl[2] = '{3'd2, 5'd0,     5'd1, 5'd2, 5'd9, 4, 0, 0, 1, 0};
    tbl[3] = '{3'd0, 5'h1f,    5'd5, 5'd6, 5'd8, 4, 0, 1, 0, 0};
    tbl[4] = '{3'd5, 5'd3,     5'd9, 5'd10, 5'd11, 1, 1, 0, 0, 0};
    tbl[5] = '{3'd3, 5'd4,     5'd12, 5'd13, 5'd14, 1, 0, 0, 0, 0};
    tbl[6] = '{3'd4, 5'd1,     5'd15, 5'd16, 5'd17, 1, 1, 0, 0, 0};
    tbl[7] = '{3'd7, 5'd2,     5'd18, 5'd19, 5'd20, 1, 1, 0, 0, 0};

    // Reset state, including a command offered while reset is held.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    check("reset_ctl", 32'(ctl_now()), 32'h40);
    check("reset_addr", 32'(addr_now()), 32'd0);
    bus.cmd_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 32'(ctl_now()), 32'h40);

    // Directed table, issued back-to-back (includes STORE followed by ALU).
    foreach (tbl[i]) begin
      run_cmd(tbl[i].op, tbl[i].aluc, tbl[i].rs, tbl[i].rt, tbl[i].rd,
              o_lat, o_err, o_regw, o_memw, o_memr);
      check("tbl_latency", 32'(o_lat), 32'(tbl[i].lat));
      check("tbl_err", 32'(o_err), 32'(tbl[i].err));
      check("tbl_regw_cycles", 32'(o_regw), 32'(tbl[i].nregw));
      check("tbl_memw_cycles", 32'(o_memw), 32'(tbl[i].nmemw));
      check("tbl_memr_cycles", 32'(o_memr), 32'(tbl[i].nmemr));
    end
    @(negedge clk);
    check("idle_after_tbl", 32'(ctl_now()), 32'h40);
    check("hold_after_tbl", 32'(addr_now()), 32'({last_rs, last_rt, last_rd, last_aluc}));

    // Reset in the MEM state of a LOAD aborts without waiting for a clock edge.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd1;
    bus.cmd_rs    = 5'd3;
    bus.cmd_rt    = 5'd4;
    bus.cmd_rd    = 5'd7;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_load_memr", 32'(bus.memr), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("async_abort_ctl", 32'(ctl_now()), 32'h40);
    check("async_abort_addr", 32'(addr_now()), 32'd0);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("held_in_reset", 32'(ctl_now()), 32'h40);
    bus.cmd_valid = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("no_done_after_abort", 32'(ctl_now()), 32'h40);
    end

    // Randomized commands with random idle gaps or back-to-back issue.
    for (int n = 0; n < 80; n++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      run_cmd(op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              o_lat, o_err, o_regw, o_memw, o_memr);
      check("rnd_latency", 32'(o_lat), 32'(latency_of(op)));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        @(negedge clk);
        check("rnd_idle", 32'(ctl_now()), 32'h40);
        check("rnd_hold", 32'(addr_now()), 32'({last_rs, last_rt, last_rd, last_aluc}));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/datapath_seq.md
DATAPATH_SEQ -- requirements
Module: datapath_seq

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock; the only clock.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port: cmd_valid  input  1  requester has a command.
REQ-004 SHALL have port: cmd_ready  output  1  sequencer can accept a command.
REQ-005 SHALL have port: cmd_op  input  3  0=ALU, 1=LOAD, 2=STORE, 3=NOP, 4..7 illegal.
REQ-006 SHALL have port: cmd_aluc  input  5  ALU function code.
REQ-007 SHALL have ports: cmd_rs, cmd_rt, cmd_rd  input  5 each  source A, source B, destination register.
REQ-008 SHALL have ports: r1, r2  output  5 each  register-file read addresses.
REQ-009 SHALL have port: wr_addr  output  5  register-file write address.
REQ-010 SHALL have port: ALUc  output  5  ALU control to datapath.
REQ-011 SHALL have ports: regw, memw, memr  output  1 each  register write, memory write, memory read strobes.
REQ-012 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port: err  output  1  one-cycle pulse, concurrent with done, for an illegal cmd_op.

Function
REQ-015 SHALL drive all outputs from registers, so they change only just after a rising clk edge (or on reset).
REQ-016 SHALL implement states IDLE, DECODE, EXEC, MEM, WB.
REQ-017 SHALL assert cmd_ready only in IDLE; a handshake occurs on a clk edge with cmd_valid=1 and cmd_ready=1.
REQ-018 SHALL latch cmd_op, cmd_aluc, cmd_rs, cmd_rt and cmd_rd at the handshake, and hold them unchanged until the next handshake.
REQ-019 SHALL drive r1=rs, r2=rt, wr_addr=rd and ALUc=aluc from the latched values.
REQ-020 SHALL follow these transitions after the handshake:
- ALU: IDLE->DECODE->EXEC->WB->IDLE.
- LOAD: IDLE->DECODE->EXEC->MEM->WB->IDLE.
- STORE: IDLE->DECODE->EXEC->MEM->IDLE.
- NOP and illegal: IDLE->IDLE, with no strobes.
REQ-021 SHALL assert the strobes as follows:
- regw=1 only in WB.
- memw=1 only in MEM of a STORE.
- memr=1 in MEM and WB of a LOAD.
- All other strobe cycles 0; each strobe lasts exactly one state (two cycles for memr on LOAD).
REQ-022 SHALL pulse done for one cycle in the first IDLE cycle after the command's last state. For NOP and illegal commands, that is the cycle after the handshake.
REQ-023 SHALL give fixed latency from handshake edge to done high: ALU 4 cycles, LOAD 5, STORE 4, NOP and illegal 1.
REQ-024 SHALL be able to accept a new command in the same cycle that done is high (back-to-back, no bubble).
REQ-025 SHALL ignore cmd_* inputs while busy=1, and SHALL never assert regw and memw in the same cycle.
REQ-026 SHALL pulse err together with done for cmd_op 4..7; a legal op SHALL never raise err.

Reset
REQ-027 SHALL, while reset=1, force:
- state=IDLE.
- cmd_ready=1; busy, done, err, regw, memw, memr all 0.
- r1, r2, wr_addr and ALUc = 0.
REQ-028 SHALL, when reset is asserted mid-command, abort the command immediately, with no done or err pulse and no strobe completing.
REQ-029 SHALL leave IDLE only on a handshake after reset deasserts.

Verification
REQ-030 SHALL verify ALU: op=0, rs=0, rt=1, rd=2, aluc=5'b00010 -> r1=0, r2=1, ALUc=2 stable from DECODE; regw=1 for exactly one cycle with wr_addr=2; done 4 cycles after the handshake.
REQ-031 SHALL verify LOAD: op=1, rs=3, rt=4, rd=7 -> memr=1 for 2 cycles (MEM, WB); regw=1 in the second of those cycles; memw=0 throughout; done at +5.
REQ-032 SHALL verify STORE then back-to-back ALU: STORE rs=1, rt=2; a second cmd_valid held high -> memw=1 one cycle; regw=0 for the whole STORE; the ALU command is accepted in the done cycle.
REQ-033 SHALL verify illegal and NOP: op=5 -> done=1 and err=1 at +1 with no strobes; op=3 -> done=1, err=0 at +1.
REQ-034 SHALL verify reset mid-LOAD: assert reset in MEM -> memr=0 and busy=0 without waiting for clk; no done pulse; cmd_ready=1 once reset deasserts.
REQ-035 SHALL verify input hold: change cmd_rs/cmd_rd while busy -> r1 and wr_addr keep their latched values until the next handshake.
